// File: rtl/memory_delay_tank.sv
// Recirculating serial delay-line memory: WORDS slots of WORD_BITS bits each.
// Optional display-tube monitor output enabled by defining MEMORY_TANK_MONITOR_EN.
module memory_delay_tank #(
    parameter int WORD_BITS = 36,
    parameter int WORDS     = 16,
    parameter int ADDR_W    = 4,
    parameter int BIT_W     = 6
) (
    input  logic              tank_clk,
    input  logic              tank_rst_n,
    input  logic              tank_mib,
    input  logic              tank_wr,
    input  logic              tank_clr,
    input  logic              tank_rd,
    input  logic [ADDR_W-1:0] tank_addr,
    output logic              tank_mob,
    output logic [BIT_W-1:0]  tank_bit_pos,
    output logic [ADDR_W-1:0] tank_word_pos,
    output logic              tank_word_sync
`ifdef MEMORY_TANK_MONITOR_EN
    ,
    output logic              tank_monitor
`endif
);

    localparam int DEPTH = WORDS * WORD_BITS;

    logic [DEPTH-1:0]  store_q, store_d;
    logic [BIT_W-1:0]  bit_pos_q, bit_pos_d;
    logic [ADDR_W-1:0] word_pos_q, word_pos_d;
    logic              mob_q, mob_d;
    logic              head_bit;
    logic              match;
    logic              tail_bit;

    // The head slot and the tail slot are the same word/bit position; the
    // tail bit re-enters the store and is seen at the head DEPTH cycles later.
    always_comb begin
        head_bit = store_q[DEPTH-1];
        match    = (word_pos_q == tank_addr);
        tail_bit = head_bit;
        if (match && tank_clr) begin
            tail_bit = 1'b0;
        end else if (match && tank_wr) begin
            tail_bit = tank_mib;
        end
        store_d = {store_q[DEPTH-2:0], tail_bit};
        mob_d   = head_bit & match & tank_rd;

        bit_pos_d  = bit_pos_q + 1'b1;
        word_pos_d = word_pos_q;
        if (bit_pos_q == BIT_W'(WORD_BITS - 1)) begin
            bit_pos_d = '0;
            if (word_pos_q == ADDR_W'(WORDS - 1)) begin
                word_pos_d = '0;
            end else begin
                word_pos_d = word_pos_q + 1'b1;
            end
        end
    end

    always_ff @(posedge tank_clk) begin
        if (!tank_rst_n) begin
            store_q    <= '0;
            bit_pos_q  <= '0;
            word_pos_q <= '0;
            mob_q      <= 1'b0;
        end else begin
            store_q    <= store_d;
            bit_pos_q  <= bit_pos_d;
            word_pos_q <= word_pos_d;
            mob_q      <= mob_d;
        end
    end

    assign tank_mob       = mob_q;
    assign tank_bit_pos   = bit_pos_q;
    assign tank_word_pos  = word_pos_q;
    assign tank_word_sync = (bit_pos_q == '0);

`ifdef MEMORY_TANK_MONITOR_EN
    logic monitor_q, monitor_d;

    always_comb begin
        monitor_d = head_bit;
    end

    always_ff @(posedge tank_clk) begin
        if (!tank_rst_n) begin
            monitor_q <= 1'b0;
        end else begin
            monitor_q <= monitor_d;
        end
    end

    assign tank_monitor = monitor_q;
`endif

endmodule

// File: tb/tb_memory_delay_tank.sv
// Directed bench for memory_delay_tank with a per-slot reference of the store.
// Uses ADDR_W = 5 so an out-of-range address (16) can be driven.
module tb_memory_delay_tank;

    localparam int WORD_BITS = 36;
    localparam int WORDS     = 16;
    localparam int ADDR_W    = 5;
    localparam int BIT_W     = 6;
    localparam int DEPTH     = WORDS * WORD_BITS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mib = 1'b0;
    logic              wr = 1'b0;
    logic              clr = 1'b0;
    logic              rd = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              mob;
    logic [BIT_W-1:0]  bit_pos;
    logic [ADDR_W-1:0] word_pos;
    logic              word_sync;
`ifdef MEMORY_TANK_MONITOR_EN
    logic              monitor;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic exp_mem [DEPTH];

    memory_delay_tank #(
        .WORD_BITS(WORD_BITS),
        .WORDS    (WORDS),
        .ADDR_W   (ADDR_W),
        .BIT_W    (BIT_W)
    ) dut (
        .tank_clk      (clk),
        .tank_rst_n    (rst_n),
        .tank_mib      (mib),
        .tank_wr       (wr),
        .tank_clr      (clr),
        .tank_rd       (rd),
        .tank_addr     (addr),
        .tank_mob      (mob),
        .tank_bit_pos  (bit_pos),
        .tank_word_pos (word_pos),
        .tank_word_sync(word_sync)
`ifdef MEMORY_TANK_MONITOR_EN
        ,
        .tank_monitor  (monitor)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s at slot %0d: observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    // One clock: predict from the reference, advance, then compare #1 after the edge.
    task automatic step();
        int   slot;
        int   w;
        int   next_cyc;
        logic exp_mob;
        logic exp_mon;
        slot = cyc % DEPTH;
        w    = slot / WORD_BITS;
        if (!rst_n) begin
            exp_mob = 1'b0;
            exp_mon = 1'b0;
            for (int i = 0; i < DEPTH; i++) exp_mem[i] = 1'b0;
            next_cyc = 0;
        end else begin
            exp_mob = exp_mem[slot] & (int'(addr) == w) & rd;
            exp_mon = exp_mem[slot];
            if (int'(addr) == w && clr) exp_mem[slot] = 1'b0;
            else if (int'(addr) == w && wr) exp_mem[slot] = mib;
            next_cyc = (cyc + 1) % DEPTH;
        end
        @(posedge clk);
        #1;
        cyc = next_cyc;
        chk("mob", 32'(mob), 32'(exp_mob));
        chk("bit_pos", 32'(bit_pos), 32'(cyc % WORD_BITS));
        chk("word_pos", 32'(word_pos), 32'(cyc / WORD_BITS));
        chk("word_sync", 32'(word_sync), 32'((cyc % WORD_BITS) == 0));
`ifdef MEMORY_TANK_MONITOR_EN
        chk("monitor", 32'(monitor), 32'(exp_mon));
`else
        if (exp_mon === 1'bx) chk("monitor_ref", 32'(exp_mon), 32'(1'b0));
`endif
    endtask

    task automatic idle();
        wr = 1'b0; clr = 1'b0; rd = 1'b0; mib = 1'b0; addr = '0;
    endtask

    task automatic goto_word(input int w);
        idle();
        while (cyc != w * WORD_BITS) step();
    endtask

    // Drive one word slot with the given gates; mib alternates when alt is set.
    task automatic word_pass(input int w, input logic w_en, input logic c_en,
                             input logic r_en, input logic alt, input logic val);
        goto_word(w);
        for (int i = 0; i < WORD_BITS; i++) begin
            addr = ADDR_W'(w);
            wr   = w_en;
            clr  = c_en;
            rd   = r_en;
            mib  = alt ? ((i % 2 == 0) ? val : ~val) : val;
            step();
        end
        idle();
    endtask

    // Full pass reading whichever word is at the head.
    task automatic read_all();
        goto_word(0);
        for (int i = 0; i < DEPTH; i++) begin
            addr = ADDR_W'(cyc / WORD_BITS);
            rd   = 1'b1;
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_mob", 32'(mob), 32'd0);
        chk("reset_sync", 32'(word_sync), 32'd1);
        rst_n = 1'b1;

        // Idle recirculation: counters, sync pulses and word wrap at 576.
        repeat (DEPTH) step();
        chk("wrap_word_pos", 32'(word_pos), 32'd0);
        chk("wrap_bit_pos", 32'(bit_pos), 32'd0);

        // Alternating 1,0 into word 3, read back on two later passes.
        word_pass(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        goto_word(3);
        addr = 5'd3; rd = 1'b1;
        step();
        chk("read_first_bit", 32'(mob), 32'd1);
        step();
        chk("read_second_bit", 32'(mob), 32'd0);
        word_pass(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        word_pass(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Read and write together: old value out, inverted pattern recirculates.
        word_pass(3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        word_pass(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // All ones, then clear with write also active: clear wins.
        word_pass(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        word_pass(3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        word_pass(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Partial-word write into word 9 and a sparse pattern in word 15.
        goto_word(9);
        for (int i = 0; i < 10; i++) begin
            addr = 5'd9; wr = (i >= 4); mib = 1'b1;
            step();
        end
        idle();
        word_pass(15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Out-of-range address for a whole pass: nothing written, nothing read.
        goto_word(0);
        for (int i = 0; i < DEPTH; i++) begin
            addr = 5'd16; wr = 1'b1; rd = 1'b1; mib = 1'b1;
            step();
        end
        idle();
        read_all();

        // Reset in the middle of writing word 5.
        goto_word(5);
        for (int i = 0; i < 10; i++) begin
            addr = 5'd5; wr = 1'b1; mib = 1'b1;
            step();
        end
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("post_reset_bit_pos", 32'(bit_pos), 32'd0);
        chk("post_reset_word_pos", 32'(word_pos), 32'd0);
        idle();
        step();
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_delay_tank.md
MEMORY_DELAY_TANK -- requirements
Module: memory_delay_tank

Interface
REQ-001 Parameter WORD_BITS, default 36: bit positions per word slot (35 data bits plus 1 gap digit).
REQ-002 Parameter WORDS, default 16: word slots circulating in the tank.
REQ-003 Parameter ADDR_W, default 4: address width; 2**ADDR_W SHALL be >= WORDS.
REQ-004 Parameter BIT_W, default 6: bit-position counter width; 2**BIT_W SHALL be >= WORD_BITS.
REQ-005 tank_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 tank_rst_n  in  1  reset, synchronous, active-low.
REQ-007 tank_mib  in  1  serial memory input bit.
REQ-008 tank_wr  in  1  write gate: replace the circulating bit with tank_mib.
REQ-009 tank_clr  in  1  clear gate: replace the circulating bit with 0.
REQ-010 tank_rd  in  1  read gate: pass the circulating bit to tank_mob.
REQ-011 tank_addr  in  ADDR_W  selected word slot.
REQ-012 tank_mob  out  1  registered serial memory output bit.
REQ-013 tank_bit_pos  out  BIT_W  bit position of the current head bit.
REQ-014 tank_word_pos  out  ADDR_W  word slot of the current head bit.
REQ-015 tank_word_sync  out  1  high while tank_bit_pos == 0.

Function
REQ-016 Store: circulating shift register of DEPTH = WORDS*WORD_BITS bits; the head bit leaves the store and a new tail bit enters on every clock; recirculation period is DEPTH cycles (576 at defaults).
REQ-017 tank_bit_pos increments every clock and wraps from WORD_BITS-1 to 0; on that wrap, tank_word_pos increments and wraps from WORDS-1 to 0.
REQ-018 match = (tank_word_pos == tank_addr); a tank_addr >= WORDS never matches, so no write or clear occurs and tank_mob stays 0.
REQ-019 Tail bit: 0 if match && tank_clr; else tank_mib if match && tank_wr; else the head bit (tank_clr has priority over tank_wr).
REQ-020 Gates are sampled per bit, so partial-word writes, clears and reads are legal.
REQ-021 tank_mob = head bit && match && tank_rd, registered, with 1-cycle latency; it is 0 otherwise.
REQ-022 A bit written at the tail SHALL reappear at the head exactly DEPTH cycles later.
REQ-023 Simultaneous read and write of the same bit: tank_mob carries the old head value, and the new value recirculates.
REQ-024 tank_addr changes take effect on the next bit, with no word-boundary alignment enforced.

Reset
REQ-025 While tank_rst_n = 0 at a clock edge: all store bits are 0, tank_bit_pos = 0, tank_word_pos = 0, and tank_mob = 0.
REQ-026 Following from REQ-015, tank_word_sync is 1 in the first cycle after reset.
REQ-027 Reset asserted mid-operation discards any write in progress; no partial state survives.

Configuration
REQ-028 Macro MEMORY_TANK_MONITOR_EN defined: adds output tank_monitor (1 bit), a registered copy of the head bit regardless of match or gates, 1-cycle latency, reset to 0; it drives the display-tube monitor.
REQ-029 Macro MEMORY_TANK_MONITOR_EN undefined: port tank_monitor and its register are absent, and all other behaviour is identical.

Verification
REQ-030 Reset, then idle for 576 cycles -> tank_mob = 0 throughout; tank_word_sync pulses at cycles 0, 36, 72 and so on; tank_word_pos wraps 15 -> 0 at cycle 576.
REQ-031 addr = 3, wr = 1 for one word, tank_mib = alternating 1,0 starting at word_sync -> with addr = 3 and rd = 1 on the next pass, tank_mob reproduces 1,0,... delayed by 1 cycle, and it repeats every 576 cycles.
REQ-032 Word 3 loaded with all ones, then clr = 1 and wr = 1 together with tank_mib = 1 for word 3 -> the next read of word 3 returns all zeros.
REQ-033 addr = 16 with WORDS = 16 and ADDR_W = 5, wr = 1 and rd = 1 for a full pass -> store unchanged and tank_mob = 0.
REQ-034 tank_rst_n = 0 asserted mid-write of word 5 -> after release, a read of every word returns 0 and the counters restart at 0.
REQ-035 WORD_BITS = 18, WORDS = 32 with MEMORY_TANK_MONITOR_EN defined -> period is 576 cycles, and tank_monitor mirrors the head bit with 1-cycle latency.
